seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param.sv | 128 ++++++++++++
 tb/tb_seq_detector_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with a Mealy match output.
// Optional saturating detection counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detector_param #(
    parameter int                 MAX_LEN       = 8,
    parameter int                 RESET_LEN     = 3,
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(3'b101),
    parameter bit                 RESET_OVERLAP = 1'b1,
    parameter int                 CNT_W         = 8,
    localparam int                LEN_W         = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               z,
    output logic               active
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0]   det_count
`endif
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               active_q, active_d;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               bits_eq;
    logic               fill_ok;
    logic               match;

    always_comb begin
        window = {hist_q, x};
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        bits_eq = (((window ^ pat_q) & mask) == '0);
        fill_ok = (fill_q >= (len_q - LEN_W'(1)));
        match   = in_valid & ~cfg_load & (len_q != '0) & fill_ok & bits_eq;
    end

    // Mealy output; forced low while reset is held
    assign z      = match & ~reset;
    assign active = active_q;

    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        active_d = active_q;
        if (cfg_load) begin
            pat_d    = cfg_pattern;
            len_d    = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
            ovl_d    = cfg_overlap;
            hist_d   = '0;
            fill_d   = '0;
            active_d = (cfg_len != '0);
        end else if (in_valid) begin
            if (match && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[MAX_LEN-2:0];
                fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q    <= RESET_PATTERN;
            len_q    <= LEN_W'(RESET_LEN);
            ovl_q    <= RESET_OVERLAP;
            hist_q   <= '0;
            fill_q   <= '0;
            active_q <= (RESET_LEN != 0);
        end else begin
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            active_q <= active_d;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign det_count = cnt_q;
`else
    // CNT_W only sizes the optional counter
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: vector tables plus scoreboard of expected z.
// Counter checks compile in when SEQ_DET_COUNT_EN is defined.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               x;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               z;
    logic               active;
`ifdef SEQ_DET_COUNT_EN
    logic [1:0]         det_count;
`endif

    always #5 clk = ~clk;

    seq_detector_param #(
        .MAX_LEN      (MAX_LEN),
        .RESET_LEN    (3),
        .RESET_PATTERN(8'b0000_0101),
        .RESET_OVERLAP(1'b1),
        .CNT_W        (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .x          (x),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .z          (z),
        .active     (active)
`ifdef SEQ_DET_COUNT_EN
        ,
        .det_count  (det_count)
`endif
    );

    typedef struct {
        logic vld;
        logic xb;
        logic exp_z;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; z is compared against the scoreboard at the falling edge.
    task automatic step(input logic vld, input logic xb, input logic ez, input string name);
        logic e;
        @(posedge clk);
        #1;
        in_valid = vld;
        x        = xb;
        cfg_load = 1'b0;
        exp_q.push_back(ez);
        @(negedge clk);
        e = exp_q.pop_front();
        check(name, {31'd0, z}, {31'd0, e});
    endtask

    task automatic load(input int len, input logic [MAX_LEN-1:0] pat, input logic ovl,
                        input logic vld, input logic xb);
        logic e;
        @(posedge clk);
        #1;
        in_valid    = vld;
        x           = xb;
        cfg_load    = 1'b1;
        cfg_len     = LEN_W'(len);
        cfg_pattern = pat;
        cfg_overlap = ovl;
        exp_q.push_back(1'b0);
        @(negedge clk);
        e = exp_q.pop_front();
        check("z_on_load", {31'd0, z}, {31'd0, e});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        x        = 1'b1;
        cfg_load = 1'b0;
        #2;
        check("z_in_reset", {31'd0, z}, 32'd0);
        check("active_reset", {31'd0, active}, 32'd1);
`ifdef SEQ_DET_COUNT_EN
        check("cnt_reset", {30'd0, det_count}, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        x        = 1'b0;
    endtask

    task automatic add(input logic vld, input logic xb, input logic ez);
        vecs.push_back('{vld, xb, ez});
    endtask

    task automatic run_vecs(input string name);
        foreach (vecs[i]) step(vecs[i].vld, vecs[i].xb, vecs[i].exp_z, name);
        vecs.delete();
    endtask

`ifdef SEQ_DET_COUNT_EN
    int cnt_exp[5] = '{1, 2, 3, 3, 3};
`endif

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        x           = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        do_reset();

        // Reset defaults: 101 overlapping
        add(1, 1, 0); add(1, 0, 0); add(1, 1, 1); add(1, 0, 0); add(1, 1, 1);
        run_vecs("t1_default_101");

        // 101 non-overlapping
        load(3, 8'b0000_0101, 1'b0, 1'b0, 1'b0);
        add(1, 1, 0); add(1, 0, 0); add(1, 1, 1); add(1, 0, 0);
        add(1, 1, 0); add(1, 0, 0); add(1, 1, 1);
        run_vecs("t2_nonoverlap");

        // 1101 overlapping with two idle cycles between bits
        load(4, 8'b0000_1101, 1'b1, 1'b0, 1'b0);
        begin
            logic [6:0] bits;
            logic [6:0] hits;
            bits = 7'b1011011;
            hits = 7'b1001000;
            for (int i = 0; i < 7; i++) begin
                add(1, bits[i], hits[i]);
                if (i < 6) begin
                    add(0, 1, 0);
                    add(0, 0, 0);
                end
            end
        end
        run_vecs("t3_gapped_1101");

        // Reset mid-sequence loses the partial match
        do_reset();
        step(1, 1, 0, "t4_pre1");
        step(1, 0, 0, "t4_pre0");
        do_reset();
        step(1, 1, 0, "t4_after_reset");
        step(1, 1, 0, "t4_seq_a");
        step(1, 0, 0, "t4_seq_b");
        step(1, 1, 1, "t4_seq_match");
        step(1, 1, 0, "t4_tail_a");
        step(1, 0, 0, "t4_tail_b");
        // Load collides with a completing bit
        load(3, 8'b0000_0101, 1'b1, 1'b1, 1'b1);
        step(1, 1, 0, "t4_hist_cleared");
        step(1, 0, 0, "t4_post_a");
        step(1, 1, 1, "t4_post_match");

        // Length 0 disables detection
        load(0, 8'b0000_0101, 1'b1, 1'b0, 1'b0);
        step(0, 0, 0, "t5_idle");
        check("t5_active_off", {31'd0, active}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1'($urandom_range(0, 1)), 0, "t5_len0");
        end

        // Length 1 mirrors x on valid cycles
        load(1, 8'b0000_0001, 1'b1, 1'b0, 1'b0);
        step(0, 0, 0, "t5_idle1");
        check("t5_active_on", {31'd0, active}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            logic v, b;
            v = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            add(v, b, v & b);
        end
        run_vecs("t5_len1");

        // Pattern bits above the length are ignored
        load(2, 8'b1111_1101, 1'b1, 1'b0, 1'b0);
        add(1, 1, 0); add(1, 0, 0); add(1, 1, 1); add(1, 1, 0);
        run_vecs("t7_upper_ignored");

        // Oversized length clamps to MAX_LEN; history fill saturates
        load(15, 8'hA5, 1'b1, 1'b0, 1'b0);
        begin
            logic [7:0] p;
            p = 8'hA5;
            for (int r = 0; r < 2; r++) begin
                for (int i = 7; i >= 0; i--) begin
                    add(1, p[i], (i == 0));
                end
            end
        end
        run_vecs("t8_clamp_len");

`ifdef SEQ_DET_COUNT_EN
        do_reset();
        begin
            int m;
            m = 0;
            for (int k = 0; k < 11; k++) begin
                logic b, ez;
                b  = (k % 2 == 0);
                ez = (k >= 2) && b;
                step(1, b, ez, "t6_z");
                if (ez) begin
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                    @(negedge clk);
                    check("t6_det_count", {30'd0, det_count}, 32'(cnt_exp[m]));
                    m++;
                end
            end
        end
        load(3, 8'b0000_0101, 1'b1, 1'b0, 1'b0);
        step(0, 0, 0, "t6_idle");
        check("t6_cnt_cleared", {30'd0, det_count}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
